cf_math_arb: RTL
================

CF_MATH_ARB -- requirements
Module: cf_math_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: operand and result width, 8..64.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid_i, input, NUM_REQ: per-requester request valid.
REQ-006 SHALL have port req_ready_o, output, NUM_REQ: per-requester accept.
REQ-007 SHALL have port req_op_i, input, NUM_REQ x 1: operation, 0 = CEIL_DIV, 1 = CLOG2.
REQ-008 SHALL have port req_a_i, input, NUM_REQ x DATA_WIDTH: dividend (CEIL_DIV) or argument (CLOG2), unsigned.
REQ-009 SHALL have port req_b_i, input, NUM_REQ x DATA_WIDTH: divisor, unsigned; ignored for CLOG2.
REQ-010 SHALL have port rsp_valid_o, output, 1: result valid.
REQ-011 SHALL have port rsp_ready_i, input, 1: consumer accepts result.
REQ-012 SHALL have port rsp_id_o, output, $clog2(NUM_REQ): index of the served requester.
REQ-013 SHALL have port rsp_result_o, output, DATA_WIDTH: result.
REQ-014 SHALL have port rsp_err_o, output, 1: division by zero flag.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, RESP; one operation in flight.
REQ-016 In IDLE with any req_valid_i set, SHALL grant the first valid index at or after rr_ptr (wrapping), assert req_ready_o for that index only, in the same cycle, combinationally from req_valid_i and rr_ptr.
REQ-017 req_ready_o SHALL be all-zero outside IDLE.
REQ-018 On grant SHALL capture op, a, b and id; set rr_ptr = granted index + 1, wrapping to 0 after NUM_REQ-1.
REQ-019 CEIL_DIV with b != 0: SHALL go to CALC; restoring shift-subtract division, one quotient bit per cycle, exactly DATA_WIDTH CALC cycles; then RESP.
REQ-020 CEIL_DIV result SHALL be q + (r != 0); this cannot overflow because r != 0 implies b >= 2.
REQ-021 CEIL_DIV with b == 0: SHALL skip CALC and go directly to RESP with rsp_err_o = 1 and rsp_result_o = all ones.
REQ-022 CLOG2: SHALL load v = a - 1, saturating at 0 for a = 0, and count = 0.
REQ-023 In each CLOG2 CALC cycle: if v == 0, SHALL go to RESP with result = count; else v >>= 1 and count++. CALC therefore lasts result + 1 cycles.
REQ-024 CLOG2 SHALL give clog2(0) = clog2(1) = 0, and rsp_err_o = 0.
REQ-025 In RESP, rsp_valid_o SHALL be 1 and rsp_id_o, rsp_result_o, rsp_err_o SHALL stay stable until rsp_ready_i = 1.
REQ-026 On the RESP handshake cycle, SHALL return to IDLE; the earliest next grant is the following cycle. No grant occurs in the handshake cycle.
REQ-027 Outside RESP, rsp_valid_o SHALL be 0 and rsp_result_o, rsp_id_o, rsp_err_o SHALL be 0.
REQ-028 A requester dropping req_valid_i before grant SHALL lose nothing; requests are not latched before grant.

Reset
REQ-029 rst_i assertion SHALL asynchronously force IDLE, rr_ptr = 0, and clear all datapath registers and outputs to 0, including mid-CALC or mid-RESP; the in-flight operation is discarded.
REQ-030 First grant after reset release SHALL be possible on the first rising edge with rst_i low.

Structure
REQ-031 Shared package cf_math_pkg SHALL hold the op typedef (CEIL_DIV, CLOG2) and the FSM state typedef.
REQ-032 Iterative datapath SHALL be sub-module cf_math_iter, with start/op/a/b in and busy/done/result/err out; cf_math_arb holds arbitration, FSM and response registers.

Verification
REQ-033 Req0 CEIL_DIV a=7, b=2 -> after 32 CALC cycles, RESP result 4, err 0, id 0.
REQ-034 CEIL_DIV a=8, b=0 -> RESP the cycle after grant, result 0xFFFFFFFF, err 1.
REQ-035 CLOG2 a = 0, 1, 2, 5, 0x80000001 -> results 0, 0, 1, 3, 32; CALC length = result + 1.
REQ-036 All 4 requesters valid continuously, rsp_ready_i = 1 -> grant order 0, 1, 2, 3, 0; one grant per operation.
REQ-037 rsp_ready_i held low 5 cycles in RESP -> rsp_valid_o and data stable, no req_ready_o asserted.
REQ-038 rst_i pulsed mid-CALC -> outputs 0 immediately, FSM IDLE, next grant goes to index 0.

Source files
------------

// File: rtl/cf_math_pkg.sv
// Shared types for the arbitrated ceil-divide / clog2 math unit.
package cf_math_pkg;

  typedef enum logic {
    CEIL_DIV = 1'b0,
    CLOG2    = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cf_math_iter.sv
// Iterative datapath: restoring ceil division (one quotient bit per cycle)
// and shift-count clog2. Loaded by start_i, done_o marks the final cycle.
import cf_math_pkg::*;

module cf_math_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  op_e                   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  logic                  busy_q, busy_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;   // dividend/quotient shifter, or clog2 v
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]         cnt_q, cnt_d;   // division step count, or clog2 count

  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH-1:0] rem_step;
  logic [DATA_WIDTH-1:0] quo_step;
  logic                  qbit;
  logic                  last;

  // One restoring-division step plus completion/result decode
  always_comb begin
    rem_shift = {rem_q, val_q[DATA_WIDTH-1]};
    qbit      = (rem_shift >= {1'b0, b_q});
    rem_step  = qbit ? DATA_WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[DATA_WIDTH-1:0];
    quo_step  = {val_q[DATA_WIDTH-2:0], qbit};
    last      = (op_q == CEIL_DIV) ? (cnt_q == CW'(DATA_WIDTH - 1)) : (val_q == '0);
    busy_o    = busy_q;
    done_o    = busy_q && last;
    // Result is taken from the final step's outputs, so it is valid with done_o
    result_o  = (op_q == CEIL_DIV) ? (quo_step + DATA_WIDTH'(rem_step != '0))
                                   : DATA_WIDTH'(cnt_q);
    err_o     = busy_q && (op_q == CEIL_DIV) && (b_q == '0);
  end

  // Next-state for the iteration registers
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    val_d  = val_q;
    rem_d  = rem_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      op_d   = op_i;
      b_d    = b_i;
      rem_d  = '0;
      cnt_d  = '0;
      if (op_i == CLOG2) val_d = (a_i == '0) ? '0 : a_i - DATA_WIDTH'(1);
      else               val_d = a_i;
    end else if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
      end else if (op_q == CEIL_DIV) begin
        val_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CW'(1);
      end else begin
        val_d = val_q >> 1;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      op_q   <= CEIL_DIV;
      val_q  <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      val_q  <= val_d;
      rem_q  <= rem_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cf_math_arb.sv
// Round-robin arbiter in front of a single iterative math unit; holds the
// control FSM and the response registers.
import cf_math_pkg::*;

module cf_math_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_op_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic                          rsp_err_o
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned CIW = IW + 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic                  grant_found;
  logic [IW-1:0]         grant_idx;
  logic [CIW-1:0]        cand;
  op_e                   sel_op;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  logic                  iter_start, iter_busy, iter_done, iter_err;
  logic [DATA_WIDTH-1:0] iter_result;

  // Find first valid requester at or after rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = CIW'(rr_ptr_q) + CIW'(i);
      if (cand >= CIW'(NUM_REQ)) cand = cand - CIW'(NUM_REQ);
      if (!grant_found && req_valid_i[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
    sel_op = op_e'(req_op_i[grant_idx]);
    sel_a  = req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_b  = req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Control FSM: grant, wait for datapath, hold response until accepted
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    result_d    = result_q;
    err_d       = err_q;
    req_ready_o = '0;
    iter_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
          // Divide-by-zero bypasses the datapath entirely
          if (sel_op == CEIL_DIV && sel_b == '0) begin
            result_d = '1;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            iter_start = 1'b1;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (iter_busy && iter_done) begin
          result_d = iter_result;
          err_d    = iter_err;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d  = IDLE;
          id_d     = '0;
          result_d = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response outputs are forced to zero outside RESP
  always_comb begin
    rsp_valid_o  = (state_q == RESP);
    rsp_id_o     = rsp_valid_o ? id_q : '0;
    rsp_result_o = rsp_valid_o ? result_q : '0;
    rsp_err_o    = rsp_valid_o && err_q;
  end

  // Control and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  cf_math_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (iter_start),
    .op_i    (sel_op),
    .a_i     (sel_a),
    .b_i     (sel_b),
    .busy_o  (iter_busy),
    .done_o  (iter_done),
    .result_o(iter_result),
    .err_o   (iter_err)
  );

endmodule
